ghost_mode_scheduler: RTL

Parametrised scheduler for the per-ghost behaviour mode, covering N ghosts.
- Runs the global scatter/chase phase sequence.
- Runs the level-scaled frightened timer and the twinkle warning.
- Tracks the per-ghost eaten/home lifecycle and the ghost-eat point combo.
- Sits between the dots/pacman logic and the ghost_parameters/ghost_display instances, and supplies the state/twinkle/reverse signals that game_master used to produce for a fixed 4 ghosts.

---
 rtl/ghost_mode_scheduler_if.sv | 29 ++
 rtl/ghost_mode_scheduler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ghost_mode_scheduler_if.sv
// Bundle between the dots/pacman game logic (master) and the ghost mode scheduler (slave).
// Carries the frame/event inputs and the per-ghost mode, twinkle, reverse and award outputs.
interface ghost_mode_scheduler_if #(
  parameter int N_GHOSTS = 4
);
  logic                    frame_tick;
  logic                    pause;
  logic                    restart_ghosts;
  logic [3:0]              level;
  logic                    big_gum_eat;
  logic [N_GHOSTS-1:0]     ghost_eaten;
  logic [N_GHOSTS-1:0]     ghost_home;
  logic [2*N_GHOSTS-1:0]   ghost_state;
  logic [N_GHOSTS-1:0]     twinkle;
  logic [N_GHOSTS-1:0]     reverse;
  logic                    award_valid;
  logic [11:0]             award_points;
  logic                    freeze;

  modport master (
    output frame_tick, pause, restart_ghosts, level, big_gum_eat, ghost_eaten, ghost_home,
    input  ghost_state, twinkle, reverse, award_valid, award_points, freeze
  );

  modport slave (
    input  frame_tick, pause, restart_ghosts, level, big_gum_eat, ghost_eaten, ghost_home,
    output ghost_state, twinkle, reverse, award_valid, award_points, freeze
  );
endinterface

// File: rtl/ghost_mode_scheduler.sv
// Per-ghost scatter/chase/fright/eaten scheduler for N ghosts with twinkle warning and eat combo.
// Optional eat-freeze counter is enabled by defining GHOST_SCHED_EAT_FREEZE_EN.
module ghost_mode_scheduler #(
  parameter int N_GHOSTS             = 4,
  parameter int SCATTER_FRAMES       = 420,
  parameter int SHORT_SCATTER_FRAMES = 300,
  parameter int CHASE_FRAMES         = 1200,
  parameter int FRIGHT_FRAMES        = 360,
  parameter int FRIGHT_STEP          = 30,
  parameter int TWINKLE_FRAMES       = 120,
  parameter int TWINKLE_PERIOD       = 8
`ifdef GHOST_SCHED_EAT_FREEZE_EN
  ,
  parameter int EAT_FREEZE_FRAMES    = 60
`endif
) (
  input logic                   clk,
  input logic                   reset,
  ghost_mode_scheduler_if.slave bus
);
  typedef enum logic [1:0] {
    GM_SCATTER = 2'd0,
    GM_CHASE   = 2'd1,
    GM_FRIGHT  = 2'd2,
    GM_EATEN   = 2'd3
  } ghost_mode_e;

  localparam logic [15:0] SCATTER_LEN = 16'(SCATTER_FRAMES);
  localparam logic [15:0] SHORT_LEN   = 16'(SHORT_SCATTER_FRAMES);
  localparam logic [15:0] CHASE_LEN   = 16'(CHASE_FRAMES);
  localparam logic [15:0] FRIGHT_LEN  = 16'(FRIGHT_FRAMES);
  localparam logic [15:0] FRIGHT_DEC  = 16'(FRIGHT_STEP);
  localparam logic [15:0] TW_LEN      = 16'(TWINKLE_FRAMES);
  localparam logic [15:0] TW_PER      = 16'(TWINKLE_PERIOD);

  function automatic logic [15:0] phase_len(input logic [2:0] p);
    case (p)
      3'd0, 3'd2: phase_len = SCATTER_LEN;
      3'd4, 3'd6: phase_len = SHORT_LEN;
      default:    phase_len = CHASE_LEN;
    endcase
  endfunction

  function automatic logic in_window(input logic [15:0] t);
    in_window = (t != 16'd0) && (t <= TW_LEN);
  endfunction

  ghost_mode_e          gstate_r [N_GHOSTS];
  ghost_mode_e          gstate_s [N_GHOSTS];
  ghost_mode_e          global_mode_s;
  logic [2:0]           phase_r, phase_s;
  logic [15:0]          phase_tmr_r, phase_tmr_s;
  logic [15:0]          fright_tmr_r, fright_tmr_s;
  logic [15:0]          tw_cnt_r, tw_cnt_s;
  logic                 tw_tog_r, tw_tog_s;
  logic [1:0]           combo_r, combo_s;
  logic [N_GHOSTS-1:0]  twinkle_r, twinkle_s;
  logic [N_GHOSTS-1:0]  reverse_r, reverse_s;
  logic                 award_valid_r, award_valid_s;
  logic [11:0]          award_points_r, award_points_s;
  logic [15:0]          fright_prod_s, fright_len_s;
  logic                 gum_s, gum_fright_s, run_tick_s, phase_adv_s, fright_expire_s;
  logic [N_GHOSTS-1:0]  eaten_s, home_s, eaten_hit_s;
`ifdef GHOST_SCHED_EAT_FREEZE_EN
  logic [15:0]          frz_cnt_r, frz_cnt_s;
  logic                 freeze_r;
`endif

  // Next-state computation: pause masks every event so all state naturally holds.
  always_comb begin
    fright_prod_s = 16'(bus.level) * FRIGHT_DEC;
    fright_len_s  = (fright_prod_s >= FRIGHT_LEN) ? 16'd0 : (FRIGHT_LEN - fright_prod_s);
    gum_s         = bus.big_gum_eat & ~bus.pause;
    gum_fright_s  = gum_s & (fright_len_s != 16'd0);
    eaten_s       = bus.ghost_eaten & ~{N_GHOSTS{bus.pause}};
    home_s        = bus.ghost_home & ~{N_GHOSTS{bus.pause}};
`ifdef GHOST_SCHED_EAT_FREEZE_EN
    run_tick_s    = bus.frame_tick & ~bus.pause & (frz_cnt_r == 16'd0);
`else
    run_tick_s    = bus.frame_tick & ~bus.pause;
`endif

    phase_s     = phase_r;
    phase_tmr_s = phase_tmr_r;
    phase_adv_s = 1'b0;
    if (run_tick_s && (fright_tmr_r == 16'd0) && (phase_r != 3'd7)) begin
      if (phase_tmr_r == phase_len(phase_r) - 16'd1) begin
        phase_s     = phase_r + 3'd1;
        phase_tmr_s = 16'd0;
        phase_adv_s = 1'b1;
      end else begin
        phase_tmr_s = phase_tmr_r + 16'd1;
      end
    end else begin
      phase_tmr_s = phase_tmr_r;
    end
    global_mode_s = phase_s[0] ? GM_CHASE : GM_SCATTER;

    fright_tmr_s    = fright_tmr_r;
    fright_expire_s = 1'b0;
    if (gum_fright_s) begin
      fright_tmr_s = fright_len_s;
    end else if (run_tick_s && (fright_tmr_r != 16'd0)) begin
      fright_tmr_s    = fright_tmr_r - 16'd1;
      fright_expire_s = (fright_tmr_r == 16'd1);
    end else begin
      fright_tmr_s = fright_tmr_r;
    end

    // Gum clears the combo before this cycle's eats are scored, in ascending ghost order.
    combo_s        = gum_fright_s ? 2'd0 : combo_r;
    award_points_s = 12'd0;
    eaten_hit_s    = '0;
    for (int i = 0; i < N_GHOSTS; i++) begin
      if (eaten_s[i] && (gstate_r[i] == GM_FRIGHT)) begin
        eaten_hit_s[i] = 1'b1;
        award_points_s = award_points_s + (12'd200 << combo_s);
        combo_s        = (combo_s == 2'd3) ? 2'd3 : (combo_s + 2'd1);
      end else begin
        eaten_hit_s[i] = 1'b0;
      end
    end
    award_valid_s = (eaten_hit_s != '0);

    gstate_s  = gstate_r;
    reverse_s = '0;
    for (int i = 0; i < N_GHOSTS; i++) begin
      reverse_s[i] = (gum_s && (gstate_r[i] != GM_EATEN) && !eaten_hit_s[i]) ||
                     (phase_adv_s && ((gstate_r[i] == GM_SCATTER) || (gstate_r[i] == GM_CHASE)));
      case (gstate_r[i])
        GM_SCATTER, GM_CHASE: gstate_s[i] = gum_fright_s ? GM_FRIGHT : global_mode_s;
        GM_FRIGHT: begin
          if (eaten_hit_s[i]) begin
            gstate_s[i] = GM_EATEN;
          end else if (gum_fright_s) begin
            gstate_s[i] = GM_FRIGHT;
          end else if (fright_expire_s) begin
            gstate_s[i] = global_mode_s;
          end else begin
            gstate_s[i] = GM_FRIGHT;
          end
        end
        GM_EATEN: gstate_s[i] = home_s[i] ? global_mode_s : GM_EATEN;
        default:  gstate_s[i] = GM_SCATTER;
      endcase
    end

    // Toggle restarts high whenever the timer lands in the window from outside or via a reload.
    tw_tog_s = tw_tog_r;
    tw_cnt_s = tw_cnt_r;
    if (in_window(fright_tmr_s)) begin
      if (!in_window(fright_tmr_r) || gum_fright_s) begin
        tw_tog_s = 1'b1;
        tw_cnt_s = 16'd0;
      end else if (fright_tmr_s != fright_tmr_r) begin
        if (tw_cnt_r == TW_PER - 16'd1) begin
          tw_tog_s = ~tw_tog_r;
          tw_cnt_s = 16'd0;
        end else begin
          tw_tog_s = tw_tog_r;
          tw_cnt_s = tw_cnt_r + 16'd1;
        end
      end else begin
        tw_tog_s = tw_tog_r;
        tw_cnt_s = tw_cnt_r;
      end
    end else begin
      tw_tog_s = 1'b0;
      tw_cnt_s = 16'd0;
    end
    for (int i = 0; i < N_GHOSTS; i++) begin
      twinkle_s[i] = (gstate_s[i] == GM_FRIGHT) && in_window(fright_tmr_s) && tw_tog_s;
    end

`ifdef GHOST_SCHED_EAT_FREEZE_EN
    if (award_valid_s) begin
      frz_cnt_s = 16'(EAT_FREEZE_FRAMES);
    end else if (bus.frame_tick && !bus.pause && (frz_cnt_r != 16'd0)) begin
      frz_cnt_s = frz_cnt_r - 16'd1;
    end else begin
      frz_cnt_s = frz_cnt_r;
    end
`endif
  end

  // State and output registers; restart_ghosts behaves exactly like reset.
  always_ff @(posedge clk) begin
    if (reset || bus.restart_ghosts) begin
      phase_r        <= 3'd0;
      phase_tmr_r    <= 16'd0;
      fright_tmr_r   <= 16'd0;
      tw_cnt_r       <= 16'd0;
      tw_tog_r       <= 1'b0;
      combo_r        <= 2'd0;
      twinkle_r      <= '0;
      reverse_r      <= '0;
      award_valid_r  <= 1'b0;
      award_points_r <= 12'd0;
      for (int i = 0; i < N_GHOSTS; i++) begin
        gstate_r[i] <= GM_SCATTER;
      end
`ifdef GHOST_SCHED_EAT_FREEZE_EN
      frz_cnt_r      <= 16'd0;
      freeze_r       <= 1'b0;
`endif
    end else begin
      phase_r        <= phase_s;
      phase_tmr_r    <= phase_tmr_s;
      fright_tmr_r   <= fright_tmr_s;
      tw_cnt_r       <= tw_cnt_s;
      tw_tog_r       <= tw_tog_s;
      combo_r        <= combo_s;
      twinkle_r      <= twinkle_s;
      reverse_r      <= reverse_s;
      award_valid_r  <= award_valid_s;
      award_points_r <= award_points_s;
      for (int i = 0; i < N_GHOSTS; i++) begin
        gstate_r[i] <= gstate_s[i];
      end
`ifdef GHOST_SCHED_EAT_FREEZE_EN
      frz_cnt_r      <= frz_cnt_s;
      freeze_r       <= (frz_cnt_s != 16'd0);
`endif
    end
  end

  for (genvar g = 0; g < N_GHOSTS; g++) begin : g_state_out
    assign bus.ghost_state[2*g +: 2] = gstate_r[g];
  end

  assign bus.twinkle      = twinkle_r;
  assign bus.reverse      = reverse_r;
  assign bus.award_valid  = award_valid_r;
  assign bus.award_points = award_points_r;
`ifdef GHOST_SCHED_EAT_FREEZE_EN
  assign bus.freeze       = freeze_r;
`else
  assign bus.freeze       = 1'b0;
`endif
endmodule
